vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and pixel output stage. It derives a pixel strobe from the system clock and produces horizontal and vertical sync, data-enable and pixel coordinates for any mode set by parameters. Pixel colour is fetched from an upstream source (frame buffer, glyph renderer) with a configurable fixed latency, and the generator realigns sync and enable to the returned data. It sits between the pixel source and the board VGA pins.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pix_strobe_gen.sv | 15 +
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 segment defaults, RGB332 field layout and colour-bar encoding.
package vga_timing_pkg;
   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_480 = 480;
   localparam int V_FP_480     = 10;
   localparam int V_SYNC_480   = 2;
   localparam int V_BP_480     = 33;
   localparam int R_W   = 3;
   localparam int G_W   = 3;
   localparam int B_W   = 2;
   localparam int RGB_W = R_W + G_W + B_W;
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;
   // Bar 0 is black, bar 7 is white; each index bit lights one whole channel.
   function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] bar);
      return {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
   endfunction
endpackage

// File: rtl/pix_strobe_gen.sv
// pix_strobe_gen: divides the system clock into a one-clk pixel strobe every CLK_DIV clocks.
module pix_strobe_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic pix_ce
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] r_div_cnt;
   always_ff @(posedge clk)
      if (rst || pix_ce) r_div_cnt <= '0;
      else r_div_cnt <= r_div_cnt + 1'b1;
   assign pix_ce = r_div_cnt == DW'(CLK_DIV - 1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters, sync/enable decode and fetch-latency realignment of colour.
// Optional VGA_TEST_PATTERN_EN adds test_mode, which swaps pix_data for an 8-bar pattern.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_ACTIVE  = H_ACTIVE_640,
   parameter int H_FP      = H_FP_640,
   parameter int H_SYNC    = H_SYNC_640,
   parameter int H_BP      = H_BP_640,
   parameter int V_ACTIVE  = V_ACTIVE_480,
   parameter int V_FP      = V_FP_480,
   parameter int V_SYNC    = V_SYNC_480,
   parameter int V_BP      = V_BP_480,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int FETCH_LAT = 1,
   parameter int CNT_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic             test_mode,
`endif
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             fetch_req,
   input  logic [RGB_W-1:0] pix_data,
   output logic [R_W-1:0]   red,
   output logic [G_W-1:0]   green,
   output logic [B_W-1:0]   blue,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic             frame_start,
   output logic             line_start,
   output logic             pix_ce
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
   logic             w_pix_ce, w_run, w_h_last, w_v_last;
   logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
   sync_t            w_s0, w_dly;
   sync_t            r_pipe [FETCH_LAT];
   logic [RGB_W-1:0] w_rgb, r_rgb;
   logic             r_hs, r_vs, r_de;
   pix_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
      .clk   (clk),
      .rst   (rst),
      .pix_ce(w_pix_ce)
   );
   always_comb begin
      w_h_last = r_h_cnt == CNT_W'(H_TOTAL - 1);
      w_v_last = r_v_cnt == CNT_W'(V_TOTAL - 1);
      w_s0.de  = r_h_cnt < CNT_W'(H_ACTIVE) && r_v_cnt < CNT_W'(V_ACTIVE);
      w_s0.hs  = r_h_cnt >= CNT_W'(H_ACTIVE + H_FP) && r_h_cnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
      w_s0.vs  = r_v_cnt >= CNT_W'(V_ACTIVE + V_FP) && r_v_cnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
      w_dly    = r_pipe[FETCH_LAT-1];
   end
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] w_bar;
   logic [2:0] r_bar_pipe [FETCH_LAT];
   assign w_bar = 3'(r_h_cnt / CNT_W'(BAR_W));
   // Bar index rides its own delay line so it lands with the matching sync.
   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < FETCH_LAT; i++) r_bar_pipe[i] <= '0;
      else if (w_pix_ce) begin
         r_bar_pipe[0] <= w_bar;
         for (int i = 1; i < FETCH_LAT; i++) r_bar_pipe[i] <= r_bar_pipe[i-1];
      end
   assign w_rgb = test_mode ? bar_rgb(r_bar_pipe[FETCH_LAT-1]) : pix_data;
`else
   assign w_rgb = pix_data;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         for (int i = 0; i < FETCH_LAT; i++) r_pipe[i] <= '0;
         r_rgb <= '0;
         r_de  <= 1'b0;
         r_hs  <= ~HS_POL;
         r_vs  <= ~VS_POL;
      end else if (w_pix_ce) begin
         r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
         if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
         r_pipe[0] <= w_s0;
         for (int i = 1; i < FETCH_LAT; i++) r_pipe[i] <= r_pipe[i-1];
         r_rgb <= w_dly.de ? w_rgb : '0;
         r_de  <= w_dly.de;
         r_hs  <= w_dly.hs ? HS_POL : ~HS_POL;
         r_vs  <= w_dly.vs ? VS_POL : ~VS_POL;
      end
   // With CLK_DIV=1 the strobe never drops, so pulses are held off during reset.
   assign w_run       = w_pix_ce & ~rst;
   assign fetch_req   = w_run & w_s0.de;
   assign line_start  = w_run & (r_h_cnt == '0);
   assign frame_start = line_start & (r_v_cnt == '0);
   assign x           = r_h_cnt;
   assign y           = r_v_cnt;
   assign {red, green, blue} = r_rgb;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign de          = r_de;
   assign pix_ce      = w_pix_ce;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a CLK_DIV=4/FETCH_LAT=3 mode (23x11) and the 12x7 small mode.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst_a, rst_b;
   logic [7:0] pix_a, pix_b;
   logic [5:0] x_a, y_a;
   logic [3:0] x_b, y_b;
   logic [2:0] red_a, grn_a, red_b, grn_b;
   logic [1:0] blu_a, blu_b;
   logic       fetch_a, hs_a, vs_a, de_a, fs_a, ls_a, ce_a;
   logic       fetch_b, hs_b, vs_b, de_b, fs_b, ls_b, ce_b;
`ifdef VGA_TEST_PATTERN_EN
   logic       tm_a;
`endif
   int n_chk = 0;
   int n_err = 0;
   vga_timing_gen #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LAT(3), .CNT_W(6)
   ) u_dut_a (
      .clk(clk), .rst(rst_a),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(tm_a),
`endif
      .x(x_a), .y(y_a), .fetch_req(fetch_a), .pix_data(pix_a),
      .red(red_a), .green(grn_a), .blue(blu_a), .hs(hs_a), .vs(vs_a), .de(de_a),
      .frame_start(fs_a), .line_start(ls_a), .pix_ce(ce_a)
   );
   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(1), .CNT_W(4)
   ) u_dut_b (
      .clk(clk), .rst(rst_b),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(1'b0),
`endif
      .x(x_b), .y(y_b), .fetch_req(fetch_b), .pix_data(pix_b),
      .red(red_b), .green(grn_b), .blue(blu_b), .hs(hs_b), .vs(vs_b), .de(de_b),
      .frame_start(fs_b), .line_start(ls_b), .pix_ce(ce_b)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic reset_chk_a();
      check("a_rst_x", x_a, 0);
      check("a_rst_y", y_a, 0);
      check("a_rst_fetch", fetch_a, 0);
      check("a_rst_frame", fs_a, 0);
      check("a_rst_line", ls_a, 0);
      check("a_rst_de", de_a, 0);
      check("a_rst_hs", hs_a, 1);
      check("a_rst_vs", vs_a, 1);
      check("a_rst_rgb", {red_a, grn_a, blu_a}, 0);
      check("a_rst_ce", ce_a, 0);
   endtask
   // Cycle c counts clocks after reset release; strobe edges complete every 4th clock.
   task automatic run_a(input int ncyc, input bit tm);
      int n_fetch = 0;
      int n_line = 0;
      int n_frame = 0;
      for (int c = 0; c < ncyc; c++) begin
         int s, h, v, j, ph, pv;
         bit ce, act, pde;
         logic [2:0] bar;
         logic [7:0] rgb;
         @(negedge clk);
         s = c / 4;
         ce = (c % 4) == 3;
         h = s % 23;
         v = (s / 23) % 11;
         act = h < 16 && v < 6;
         pix_a = s >= 3 ? 8'((s - 3) % 23) : 8'hA5;
         check("a_pix_ce", ce_a, ce);
         check("a_fetch", fetch_a, ce && act);
         check("a_line", ls_a, ce && h == 0);
         check("a_frame", fs_a, ce && h == 0 && v == 0);
         if (s < 253) begin
            n_fetch += int'(fetch_a);
            n_line += int'(ls_a);
            n_frame += int'(fs_a);
         end
         if (ce) begin
            check("a_x", x_a, h);
            check("a_y", y_a, v);
            if (s >= 4) begin
               j = s - 4;
               ph = j % 23;
               pv = (j / 23) % 11;
               pde = ph < 16 && pv < 6;
               bar = 3'(ph / 2);
               rgb = tm ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}} : 8'(ph);
               check("a_de", de_a, pde);
               check("a_hs", hs_a, !(ph >= 18 && ph < 21));
               check("a_vs", vs_a, !(pv >= 7 && pv < 9));
               check("a_rgb", {red_a, grn_a, blu_a}, pde ? rgb : 8'h00);
            end else begin
               check("a_de_fill", de_a, 0);
               check("a_hs_fill", hs_a, 1);
               check("a_vs_fill", vs_a, 1);
               check("a_rgb_fill", {red_a, grn_a, blu_a}, 0);
            end
         end
      end
      if (ncyc >= 4 * 253) begin
         check("a_n_fetch", n_fetch, 96);
         check("a_n_line", n_line, 11);
         check("a_n_frame", n_frame, 1);
      end
   endtask
   task automatic run_b(input int ncyc);
      int n_fetch = 0;
      int n_line = 0;
      for (int c = 0; c < ncyc; c++) begin
         int h, v, j, ph, pv;
         bit act, pde;
         @(negedge clk);
         h = c % 12;
         v = (c / 12) % 7;
         act = h < 8 && v < 4;
         pix_b = c >= 1 ? {4'(((c - 1) / 12) % 7), 4'((c - 1) % 12)} : 8'h5A;
         check("b_pix_ce", ce_b, 1);
         check("b_x", x_b, h);
         check("b_y", y_b, v);
         check("b_fetch", fetch_b, act);
         check("b_line", ls_b, h == 0);
         check("b_frame", fs_b, h == 0 && v == 0);
         if (c < 84) begin
            n_fetch += int'(fetch_b);
            n_line += int'(ls_b);
         end
         if (c >= 2) begin
            j = c - 2;
            ph = j % 12;
            pv = (j / 12) % 7;
            pde = ph < 8 && pv < 4;
            check("b_de", de_b, pde);
            check("b_hs", hs_b, ph >= 9 && ph < 11);
            check("b_vs", vs_b, pv == 5);
            check("b_rgb", {red_b, grn_b, blu_b}, pde ? {4'(pv), 4'(ph)} : 8'h00);
         end
      end
      check("b_n_fetch", n_fetch, 32);
      check("b_n_line", n_line, 7);
   endtask
   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      pix_a = 8'h00;
      pix_b = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
      tm_a = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_chk_a();
      check("b_rst_x", x_b, 0);
      check("b_rst_hs", hs_b, 0);
      check("b_rst_vs", vs_b, 0);
      check("b_rst_de", de_b, 0);
      check("b_rst_fetch", fetch_b, 0);
      check("b_rst_rgb", {red_b, grn_b, blu_b}, 0);
      @(posedge clk);
      #1 rst_a = 1'b0;
      run_a(4 * 332 + 2, 1'b0);
      check("a_pre_rst_x", x_a, 10);
      check("a_pre_rst_y", y_a, 3);
      rst_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_chk_a();
      @(posedge clk);
      #1 rst_a = 1'b0;
      run_a(60, 1'b0);
`ifdef VGA_TEST_PATTERN_EN
      rst_a = 1'b1;
      tm_a = 1'b1;
      @(posedge clk);
      #1 rst_a = 1'b0;
      run_a(4 * 30, 1'b1);
`endif
      @(posedge clk);
      #1 rst_b = 1'b0;
      run_b(100);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
